pixel_frame_sequencer: RTL and testbench

PIXEL_FRAME_SEQUENCER -- requirements
Module: pixel_frame_sequencer

---
 rtl/pixel_frame_sequencer.sv | 128 ++++++++++++
 tb/tb_pixel_frame_sequencer.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_frame_sequencer.sv
// Frame sequencer: streams pixels from frame memory to a processing datapath
// through a 2-entry FIFO and writes the processed results back in address order.
module pixel_frame_sequencer #(
   parameter int ADDR_W = 19,
   parameter int PIX_W  = 24
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] cfg_npix,
   output logic              mem_rd_en,
   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [PIX_W-1:0]  mem_rd_data,
   output logic              px_valid,
   output logic [PIX_W-1:0]  px_data,
   input  logic              px_ready,
   input  logic              res_valid,
   input  logic [PIX_W-1:0]  res_data,
   output logic              res_ready,
   output logic              mem_wr_en,
   output logic [ADDR_W-1:0] mem_wr_addr,
   output logic [PIX_W-1:0]  mem_wr_data,
   output logic              busy,
   output logic              done,
   output logic [1:0]        dbg_state
);

   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] npix_q, npix_d;
   logic [ADDR_W-1:0] rd_cnt_q, rd_cnt_d;
   logic [ADDR_W-1:0] wr_cnt_q, wr_cnt_d;
   logic              inflight_q, inflight_d;
   logic [PIX_W-1:0]  fifo_q [2];
   logic [PIX_W-1:0]  fifo_d [2];
   logic              fifo_wp_q, fifo_wp_d;
   logic              fifo_rp_q, fifo_rp_d;
   logic [1:0]        fifo_cnt_q, fifo_cnt_d;

   logic active, kill, push, pop, rd_room;

   // Handshakes: a transfer happens in any cycle where valid && ready are both
   // high at the rising edge; valid never depends on ready.
   always_comb begin
      active      = (state_q == RUN) || (state_q == DRAIN);
      kill        = active && abort;
      res_ready   = active;
      busy        = active;
      done        = (state_q == DONE);
      dbg_state   = state_q;
      px_valid    = active && !abort && (fifo_cnt_q != 2'd0);
      px_data     = px_valid ? fifo_q[fifo_rp_q] : '0;
      pop         = px_valid && px_ready;
      push        = active && inflight_q;
      // Occupancy is taken net of this cycle's pop so a full-speed consumer
      // sustains one read per cycle without ever exceeding two outstanding.
      rd_room     = (({1'b0, fifo_cnt_q} - {2'b00, pop}) + {2'b00, inflight_q}) < 3'd2;
      mem_rd_en   = (state_q == RUN) && !abort && (rd_cnt_q < npix_q) && rd_room;
      mem_rd_addr = rd_cnt_q;
      mem_wr_en   = active && !abort && res_valid && (wr_cnt_q < npix_q);
      mem_wr_addr = wr_cnt_q;
      mem_wr_data = mem_wr_en ? res_data : '0;
   end

   always_comb begin
      state_d    = state_q;
      npix_d     = npix_q;
      rd_cnt_d   = mem_rd_en ? rd_cnt_q + 1'b1 : rd_cnt_q;
      wr_cnt_d   = mem_wr_en ? wr_cnt_q + 1'b1 : wr_cnt_q;
      inflight_d = mem_rd_en;
      fifo_d     = fifo_q;
      fifo_wp_d  = fifo_wp_q ^ push;
      fifo_rp_d  = fifo_rp_q ^ pop;
      fifo_cnt_d = fifo_cnt_q + {1'b0, push} - {1'b0, pop};
      if (push) fifo_d[fifo_wp_q] = mem_rd_data;

      unique case (state_q)
         IDLE: begin
            if (start) begin
               npix_d   = cfg_npix;
               rd_cnt_d = '0;
               wr_cnt_d = '0;
               state_d  = (cfg_npix == '0) ? DONE : RUN;
            end
         end
         RUN:   if (rd_cnt_q == npix_q) state_d = DRAIN;
         DRAIN: if (wr_cnt_q == npix_q) state_d = DONE;
         DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Abort drops everything buffered or still returning from memory.
      if (kill) begin
         state_d    = IDLE;
         inflight_d = 1'b0;
         fifo_wp_d  = 1'b0;
         fifo_rp_d  = 1'b0;
         fifo_cnt_d = 2'd0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         npix_q     <= '0;
         rd_cnt_q   <= '0;
         wr_cnt_q   <= '0;
         inflight_q <= 1'b0;
         fifo_q     <= '{default: '0};
         fifo_wp_q  <= 1'b0;
         fifo_rp_q  <= 1'b0;
         fifo_cnt_q <= 2'd0;
      end else begin
         state_q    <= state_d;
         npix_q     <= npix_d;
         rd_cnt_q   <= rd_cnt_d;
         wr_cnt_q   <= wr_cnt_d;
         inflight_q <= inflight_d;
         fifo_q     <= fifo_d;
         fifo_wp_q  <= fifo_wp_d;
         fifo_rp_q  <= fifo_rp_d;
         fifo_cnt_q <= fifo_cnt_d;
      end
   end

endmodule

// File: tb/tb_pixel_frame_sequencer.sv
// Bench for pixel_frame_sequencer: behavioural frame memory and datapath,
// expected pixel/write queues built from memory contents, directed frame steps.
module tb_pixel_frame_sequencer;
  localparam int ADDR_W = 19;
  localparam int PIX_W  = 24;
  localparam int MEM_N  = 4096;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;
  localparam logic [PIX_W-1:0] XKEY = 24'h5A3C96;

  // clock / reset
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [ADDR_W-1:0] cfg_npix = '0;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_rd_addr;
  logic [PIX_W-1:0]  mem_rd_data = '0;
  logic              px_valid;
  logic [PIX_W-1:0]  px_data;
  logic              px_ready = 1'b0;
  logic              res_valid = 1'b0;
  logic [PIX_W-1:0]  res_data = '0;
  logic              res_ready;
  logic              mem_wr_en;
  logic [ADDR_W-1:0] mem_wr_addr;
  logic [PIX_W-1:0]  mem_wr_data;
  logic              busy;
  logic              done;
  logic [1:0]        dbg_state;

  pixel_frame_sequencer #(.ADDR_W(ADDR_W), .PIX_W(PIX_W)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .cfg_npix(cfg_npix),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .px_valid(px_valid), .px_data(px_data), .px_ready(px_ready),
    .res_valid(res_valid), .res_data(res_data), .res_ready(res_ready),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // scoreboard state
  int vectors = 0;
  int miscompares = 0;
  logic [PIX_W-1:0]        mem [MEM_N];
  logic [PIX_W-1:0]        exp_q[$];
  logic [ADDR_W+PIX_W-1:0] exp_wr_q[$];
  logic [PIX_W-1:0]        pend_q[$];
  int                      pend_due_q[$];
  int cyc = 0;
  int ready_mode = 0;
  logic tog = 1'b1;
  logic rd_ret = 1'b0;
  logic [ADDR_W-1:0] rd_ret_addr = '0;
  logic [ADDR_W-1:0] rd_next = '0;
  logic [ADDR_W-1:0] last_wr_addr = '0;
  int frame_n = 0, rd_issued = 0, px_taken = 0, wr_seen = 0, done_seen = 0;

  function automatic logic [PIX_W-1:0] xform(input logic [PIX_W-1:0] x);
    return x ^ XKEY;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    logic hs_px, hs_res;
    hs_px  = px_valid && px_ready;
    hs_res = res_valid && res_ready && (pend_q.size() > 0);
    if (hs_px) begin
      px_taken++;
      chk("px_in_frame", px_taken <= frame_n, 1'b1);
      if (exp_q.size() > 0) chk("px_data", px_data, exp_q.pop_front());
      pend_q.push_back(xform(px_data));
      pend_due_q.push_back(cyc + 2);
    end
    if (mem_rd_en) begin
      rd_issued++;
      chk("rd_addr", mem_rd_addr, rd_next);
      chk("rd_in_frame", rd_issued <= frame_n, 1'b1);
      chk("rd_outstanding", (rd_issued - px_taken) <= 2, 1'b1);
      rd_next     = rd_next + 1'b1;
      rd_ret      = 1'b1;
      rd_ret_addr = mem_rd_addr;
    end
    if (hs_res) begin
      void'(pend_q.pop_front());
      void'(pend_due_q.pop_front());
      if (!abort) chk("wr_on_result", mem_wr_en, 1'b1);
    end
    if (mem_wr_en) begin
      wr_seen++;
      chk("wr_has_result", hs_res, 1'b1);
      chk("wr_in_frame", wr_seen <= frame_n, 1'b1);
      if (exp_wr_q.size() > 0) chk("wr_addr_data", {mem_wr_addr, mem_wr_data}, exp_wr_q.pop_front());
      last_wr_addr = mem_wr_addr;
    end
    if (done) done_seen++;
  endtask

  // memory + datapath driver on the falling edge, monitor 3 time units later
  always @(negedge clk) begin
    case (ready_mode)
      0:       px_ready = 1'b1;
      1:       begin px_ready = tog; tog = ~tog; end
      default: px_ready = 1'($urandom_range(0, 1));
    endcase
    mem_rd_data = rd_ret ? mem[rd_ret_addr[11:0]] : PIX_W'($urandom);
    if (pend_q.size() > 0 && pend_due_q[0] <= cyc) begin
      res_valid = 1'b1;
      res_data  = pend_q[0];
    end else begin
      res_valid = 1'b0;
      res_data  = PIX_W'($urandom);
    end
    #3;
    rd_ret = 1'b0;
    if (!reset) sample();
    cyc++;
  end

  task automatic arm_frame(input int n);
    frame_n = n; rd_issued = 0; px_taken = 0; wr_seen = 0; done_seen = 0;
    rd_next = '0;
    exp_q.delete();
    exp_wr_q.delete();
    for (int k = 0; k < n; k++) begin
      exp_q.push_back(mem[k]);
      exp_wr_q.push_back({ADDR_W'(k), xform(mem[k])});
    end
  endtask

  task automatic run_frame(input int n, input int mode, input bit poke, input bit with_abort,
                           input string tag);
    int waited;
    ready_mode = mode;
    tog = 1'b1;
    @(negedge clk);
    arm_frame(n);
    cfg_npix = ADDR_W'(n);
    start = 1'b1;
    abort = with_abort;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    if (poke) begin
      repeat (4) @(negedge clk);
      cfg_npix = ADDR_W'(3);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    waited = 0;
    while (done_seen == 0 && waited < 5 * n + 50) begin
      @(negedge clk);
      waited++;
    end
    repeat (3) @(negedge clk);
    #3;
    chk({tag, "_done_once"}, done_seen, 1);
    chk({tag, "_writes"}, wr_seen, n);
    chk({tag, "_pixels"}, px_taken, n);
    chk({tag, "_exp_left"}, exp_wr_q.size(), 0);
    chk({tag, "_busy_after"}, busy, 1'b0);
    chk({tag, "_idle_after"}, dbg_state, ST_IDLE);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_rd_en"}, mem_rd_en, 1'b0);
    chk({tag, "_wr_en"}, mem_wr_en, 1'b0);
    chk({tag, "_px_valid"}, px_valid, 1'b0);
    chk({tag, "_res_ready"}, res_ready, 1'b0);
    chk({tag, "_addrs"}, {mem_rd_addr, mem_wr_addr}, '0);
    chk({tag, "_data"}, {px_data, mem_wr_data}, '0);
    chk({tag, "_state"}, dbg_state, ST_IDLE);
  endtask

  initial begin
    int waited;
    for (int i = 0; i < MEM_N; i++) mem[i] = PIX_W'($urandom);

    // reset state
    repeat (2) @(negedge clk);
    #3 chk_all_zero("reset");
    @(negedge clk);
    reset = 1'b0;

    // basic 4-pixel frame, full-speed consumer
    run_frame(4, 0, 1'b0, 1'b0, "npix4");

    // 8 pixels with alternating ready; a start while busy must be ignored
    run_frame(8, 1, 1'b1, 1'b0, "npix8_toggle");

    // empty frame: done the cycle after start, no memory traffic
    @(negedge clk);
    arm_frame(0);
    cfg_npix = '0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #3;
    chk("zero_done", done, 1'b1);
    chk("zero_state", dbg_state, ST_DONE);
    @(negedge clk);
    #3;
    chk("zero_done_low", done, 1'b0);
    chk("zero_idle", dbg_state, ST_IDLE);
    chk("zero_traffic", rd_issued + wr_seen, 0);

    // randomized frame sizes with random ready
    for (int r = 0; r < 4; r++) run_frame($urandom_range(1, 40), 2, 1'b0, 1'b0, "rand");

    // long frame at full speed
    run_frame(2000, 0, 1'b0, 1'b0, "long");
    chk("long_last_addr", last_wr_addr, ADDR_W'(1999));

    // abort after 3 writes of a 10-pixel frame
    ready_mode = 0;
    @(negedge clk);
    arm_frame(10);
    cfg_npix = ADDR_W'(10);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waited = 0;
    while (wr_seen < 3 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    chk("abort_after_3_writes", wr_seen, 3);
    abort = 1'b1;
    arm_frame(0);
    #3;
    chk("abort_cycle_wr_en", mem_wr_en, 1'b0);
    chk("abort_cycle_rd_en", mem_rd_en, 1'b0);
    chk("abort_cycle_px_valid", px_valid, 1'b0);
    @(negedge clk);
    abort = 1'b0;
    #3;
    chk("abort_idle_next", dbg_state, ST_IDLE);
    chk("abort_busy_low", busy, 1'b0);
    repeat (8) @(negedge clk);
    chk("abort_no_done", done_seen, 0);
    chk("abort_no_writes", wr_seen, 0);
    pend_q.delete();
    pend_due_q.delete();

    // start and abort together in IDLE: start wins, frame restarts at 0
    run_frame(2, 0, 1'b0, 1'b1, "after_abort");
    chk("after_abort_last_addr", last_wr_addr, ADDR_W'(1));

    // reset in the middle of DRAIN
    ready_mode = 0;
    @(negedge clk);
    arm_frame(6);
    cfg_npix = ADDR_W'(6);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waited = 0;
    while (dbg_state !== ST_DRAIN && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk("drain_reached", dbg_state, ST_DRAIN);
    #2 reset = 1'b1;
    #1 chk_all_zero("mid_reset");
    pend_q.delete();
    pend_due_q.delete();
    arm_frame(0);
    @(negedge clk);
    reset = 1'b0;
    #3;
    chk("post_reset_idle", dbg_state, ST_IDLE);
    repeat (3) @(negedge clk);
    chk("post_reset_no_done", done_seen, 0);
    run_frame(2, 2, 1'b0, 1'b0, "post_reset");
    chk("post_reset_last_addr", last_wr_addr, ADDR_W'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
